morse_playback_sequencer: RTL and testbench

MORSE_PLAYBACK_SEQUENCER -- requirements
Module: morse_playback_sequencer

---
 rtl/morse_playback_sequencer.sv | 140 ++++++++++++++
 tb/tb_morse_playback_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_playback_sequencer.sv
// Morse character playback sequencer.
// Plays up to six dot/dash elements LSB first, with one-unit gaps between
// elements and a configurable silent tail, timed in units of unit_cycles.
module morse_playback_sequencer #(
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned CHAR_GAP_UNITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  sym_count,
  input  logic [5:0]  sym_bits,
  input  logic [31:0] unit_cycles,
  input  logic        abort,
  output logic        busy,
  output logic        tone_en,
  output logic [2:0]  elem_idx,
  output logic        done,
  output logic        aborted,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, TONE, GAP, TAIL} state_t;

  localparam logic [2:0] DASH_LEN = 3'(DASH_UNITS);
  localparam logic [2:0] TAIL_LEN = 3'(CHAR_GAP_UNITS);

  state_t      state;
  logic [5:0]  bits_q;
  logic [2:0]  count_q;
  logic [31:0] unit_q;
  logic [31:0] unit_cnt;
  logic [2:0]  units_left;
  logic        unit_end;
  logic [2:0]  next_idx;

  // End of one unit period and index of the element following the current one
  always_comb begin
    unit_end = (unit_cnt == unit_q - 32'd1);
    next_idx = elem_idx + 3'd1;
  end

  // Playback state machine: element length = units_left full unit periods
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bits_q     <= '0;
      count_q    <= '0;
      unit_q     <= '0;
      unit_cnt   <= '0;
      units_left <= '0;
      busy       <= 1'b0;
      tone_en    <= 1'b0;
      elem_idx   <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      err        <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        busy       <= 1'b0;
        tone_en    <= 1'b0;
        elem_idx   <= '0;
        unit_cnt   <= '0;
        units_left <= '0;
        aborted    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (sym_count == 3'd0 || sym_count == 3'd7) begin
                err <= 1'b1;
              end else begin
                bits_q     <= sym_bits;
                count_q    <= sym_count;
                unit_q     <= (unit_cycles == 32'd0) ? 32'd1 : unit_cycles;
                unit_cnt   <= '0;
                units_left <= sym_bits[0] ? DASH_LEN : 3'd1;
                elem_idx   <= '0;
                busy       <= 1'b1;
                tone_en    <= 1'b1;
                state      <= TONE;
              end
            end
          end
          TONE: begin
            if (unit_end) begin
              unit_cnt <= '0;
              if (units_left == 3'd1) begin
                tone_en <= 1'b0;
                if (elem_idx == count_q - 3'd1) begin
                  units_left <= TAIL_LEN;
                  state      <= TAIL;
                end else begin
                  units_left <= 3'd1;
                  state      <= GAP;
                end
              end else begin
                units_left <= units_left - 3'd1;
              end
            end else begin
              unit_cnt <= unit_cnt + 32'd1;
            end
          end
          GAP: begin
            if (unit_end) begin
              unit_cnt   <= '0;
              elem_idx   <= next_idx;
              units_left <= bits_q[next_idx] ? DASH_LEN : 3'd1;
              tone_en    <= 1'b1;
              state      <= TONE;
            end else begin
              unit_cnt <= unit_cnt + 32'd1;
            end
          end
          TAIL: begin
            if (unit_end) begin
              unit_cnt <= '0;
              if (units_left == 3'd1) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                elem_idx <= '0;
                state    <= IDLE;
              end else begin
                units_left <= units_left - 3'd1;
              end
            end else begin
              unit_cnt <= unit_cnt + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_playback_sequencer.sv
// Scoreboard bench for morse_playback_sequencer: stimulus pushes expected
// done/aborted/err events, a negedge monitor pops and checks them.
module tb_morse_playback_sequencer;

  localparam int DASH = 3;
  localparam int CG   = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  sym_count;
  logic [5:0]  sym_bits;
  logic [31:0] unit_cycles;
  logic        abort;
  logic        busy;
  logic        tone_en;
  logic [2:0]  elem_idx;
  logic        done;
  logic        aborted;
  logic        err;

  morse_playback_sequencer #(
    .DASH_UNITS(DASH),
    .CHAR_GAP_UNITS(CG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sym_count(sym_count),
    .sym_bits(sym_bits),
    .unit_cycles(unit_cycles),
    .abort(abort),
    .busy(busy),
    .tone_en(tone_en),
    .elem_idx(elem_idx),
    .done(done),
    .aborted(aborted),
    .err(err)
  );

  // kind: 0 = done, 1 = aborted, 2 = err
  typedef struct {
    int     kind;
    longint cyc;
    longint tone;
    longint busyc;
    int     maxidx;
  } exp_t;

  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     events = 0;
  longint cyc = 0;
  longint tone_acc = 0;
  longint busy_acc = 0;
  int     max_idx = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Busy length of a character from the timing rules
  function automatic longint total_len(input logic [5:0] b, input int n, input longint u);
    longint t;
    t = 0;
    for (int i = 0; i < n; i++) t += b[i] ? DASH * u : u;
    return t + (n - 1) * u + CG * u;
  endfunction

  // Tone-high cycles and last element index within the first 'upto' busy cycles
  function automatic void model(input logic [5:0] b, input int n, input longint u,
                                input longint upto, output longint tone, output int lastidx);
    longint t;
    longint len;
    longint left;
    t = 0;
    tone = 0;
    lastidx = 0;
    for (int i = 0; i < n; i++) begin
      len = b[i] ? DASH * u : u;
      if (t < upto) lastidx = i;
      left = upto - t;
      if (left > 0) tone += (left < len) ? left : len;
      t += len;
      if (i < n - 1) t += u;
    end
  endfunction

  // Monitor: tallies activity and checks each pulse against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      tone_acc = 0;
      busy_acc = 0;
      max_idx  = 0;
    end else begin
      tone_acc += tone_en;
      busy_acc += busy;
      if (busy && int'(elem_idx) > max_idx) max_idx = int'(elem_idx);
      if (done || aborted || err) begin
        events++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got done=%0b aborted=%0b err=%0b, expected none (cycle %0d)",
                   done, aborted, err, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("event_kind", done ? 0 : (aborted ? 1 : 2), e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (e.kind != 2) begin
            chk("tone_cycles", tone_acc, e.tone);
            chk("busy_cycles", busy_acc, e.busyc);
            chk("max_elem_idx", max_idx, e.maxidx);
            chk("idx_after", elem_idx, 0);
            chk("busy_after", busy, 0);
            chk("tone_after", tone_en, 0);
          end
        end
        tone_acc = 0;
        busy_acc = 0;
        max_idx  = 0;
      end
    end
  end

  // Plays one character; abort_off >= 0 aborts after that many busy cycles + 1.
  // noise holds an invalid start and alters inputs during playback.
  task automatic play(input logic [5:0] b, input int n, input logic [31:0] u,
                      input int abort_off, input bit noise);
    exp_t   e;
    longint uu;
    longint t;
    longint a;
    longint tn;
    int     li;
    start       = 1'b1;
    sym_bits    = b;
    sym_count   = n[2:0];
    unit_cycles = u;
    tick();
    start = 1'b0;
    if (n == 0 || n == 7) begin
      e = '{2, cyc, 0, 0, 0};
      sb.push_back(e);
      tick();
      return;
    end
    uu = (u == 0) ? 1 : longint'(u);
    t  = total_len(b, n, uu);
    if (noise) begin
      start       = 1'b1;
      sym_count   = 3'd0;
      sym_bits    = ~b;
      unit_cycles = 32'd1;
    end
    if (abort_off < 0) begin
      model(b, n, uu, t, tn, li);
      e = '{0, cyc + t, tn, t, li};
      sb.push_back(e);
      repeat (int'(t)) tick();
      start = 1'b0;
    end else begin
      a = cyc + 1 + abort_off;
      model(b, n, uu, a - cyc, tn, li);
      e = '{1, a, tn, a - cyc, li};
      sb.push_back(e);
      repeat (abort_off) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e;
    longint      e1;
    longint      t1;
    longint      t2;
    longint      tn;
    int          li;
    int          ev0;
    int          n;
    int          off;
    logic [5:0]  b;
    logic [31:0] u;
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sym_count = '0;
    sym_bits = '0;
    unit_cycles = '0;
    repeat (3) tick();
    chk("reset_outputs", {busy, tone_en, elem_idx, done, aborted, err}, 0);
    rst = 1'b0;
    tick();

    // Dot-dash, single dot with zero unit, six dashes
    play(6'b000010, 2, 32'd4, -1, 1'b0);
    play(6'b000000, 1, 32'd0, -1, 1'b0);
    play(6'b111111, 6, 32'd2, -1, 1'b0);

    // Abort in the 3rd cycle of the second tone, then restart next cycle
    play(6'b000010, 2, 32'd4, 10, 1'b0);
    play(6'b000001, 1, 32'd1, -1, 1'b0);

    // Rejections
    play(6'b000011, 0, 32'd3, -1, 1'b0);
    chk("busy_after_reject", busy, 0);
    play(6'b000011, 7, 32'd3, -1, 1'b0);

    // Abort together with start in IDLE does nothing
    start = 1'b1; abort = 1'b1; sym_count = 3'd2; sym_bits = 6'b01; unit_cycles = 32'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("abort_start_idle_busy", busy, 0);

    // Huge unit: tone stays up, invalid start ignored while busy, then abort
    play(6'b000001, 1, 32'hFFFF_FFFF, 40, 1'b1);

    // Start held through a playback: next char accepted in the done cycle
    start = 1'b1; sym_bits = 6'b000001; sym_count = 3'd2; unit_cycles = 32'd2;
    tick();
    e1 = cyc;
    t1 = total_len(6'b000001, 2, 2);
    model(6'b000001, 2, 2, t1, tn, li);
    e = '{0, e1 + t1, tn, t1, li};
    sb.push_back(e);
    sym_bits = 6'b000001; sym_count = 3'd1; unit_cycles = 32'd3;
    repeat (int'(t1) + 1) tick();
    start = 1'b0;
    chk("b2b_restart_busy", busy, 1);
    t2 = total_len(6'b000001, 1, 3);
    model(6'b000001, 1, 3, t2, tn, li);
    e = '{0, cyc + t2, tn, t2, li};
    sb.push_back(e);
    repeat (int'(t2) + 2) tick();

    // Reset during GAP: everything clears, no pulses afterwards
    start = 1'b1; sym_bits = 6'b000000; sym_count = 3'd2; unit_cycles = 32'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("reset_in_gap", {busy, tone_en, elem_idx, done, aborted, err}, 0);
    rst = 1'b0;
    ev0 = events;
    repeat (20) tick();
    chk("no_pulse_after_reset", events, ev0);

    // Random characters, some aborted, some rejected
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 7);
      b = 6'($urandom);
      u = $urandom_range(0, 4);
      off = -1;
      if (n >= 1 && n <= 6 && $urandom_range(0, 3) == 0) begin
        t1 = total_len(b, n, (u == 0) ? 1 : longint'(u));
        off = $urandom_range(0, int'(t1) - 1);
      end
      play(b, n, u, off, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
